crc32_rx_check: RTL and testbench
=================================

Name: crc32_rx_check

Overview:
- Receive-side CRC-32 checker for the 48-bit word stream whose transmit side appends a CRC-32 trailer beat.
- Accumulates CRC-32 over payload beats and compares the result against the trailer carried on the EOP beat.
- Reports one result record per packet, with pass/fail, computed CRC, word count and protocol-error flags.
- Sits between the link deserializer and the packet consumer. It monitors only; payload is not stored or forwarded.

Parameters:
- CRC_INIT, 32'hFFFFFFFF, CRC register value at packet start. No reflection and no final XOR.
- MAX_WORDS, 1024, maximum payload beats per packet, excluding the trailer. Range 1..65535.

Ports:
- CLK  input  1  clock; all logic is on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- IN_VALID  input  1  input beat valid.
- IN_READY  output  1  checker can accept a beat. A beat transfers when IN_VALID and IN_READY are both high.
- IN_DATA  input  48  payload word. On the EOP beat, [31:0] is the received CRC and [47:32] is ignored.
- IN_SOP  input  1  first beat of packet.
- IN_EOP  input  1  trailer beat of packet; SOP together with EOP means zero payload.
- OUT_VALID  output  1  result record valid; held until accepted.
- OUT_READY  input  1  consumer accepts the result.
- OUT_CRC_OK  output  1  computed CRC equals received CRC and no error flag is set.
- OUT_CRC_CALC  output  32  computed CRC over payload.
- OUT_CRC_RX  output  32  received trailer CRC.
- OUT_WORDS  output  16  payload beats counted, saturating at MAX_WORDS+1.
- OUT_ERR_LEN  output  1  payload exceeded MAX_WORDS.
- OUT_ERR_SOP  output  1  SOP arrived while a packet was open; the packet was restarted.

Behaviour:
- CRC step: polynomial 0x04C11DB7, shift left (MSB-first), 48 bits per beat.
  - Equivalent to 48 serial steps, IN_DATA[47] first: fb = crc[31]^d; crc = {crc[30:0],1'b0} ^ (fb ? poly : 0).
  - Must be bit-identical to the team's CRC_32 step module, which may be instantiated.
- Reset (RST=1 at an edge): state=IDLE, crc=CRC_INIT, count=0, sticky errors=0.
  - Outputs: IN_READY=0 during the reset cycle, then 1 in the cycle after; OUT_VALID=0; all OUT_* data=0.
  - Reset mid-packet discards the partial packet and any pending result.
- States:
  - IDLE: accepted beat without SOP is dropped silently (no state change). SOP without EOP: crc=step(CRC_INIT,data), count=1, go to BODY. SOP with EOP: build result with crc=CRC_INIT and count=0, go to RESULT.
  - BODY: beat without SOP/EOP: crc=step(crc,data), count+=1. Beat with EOP: build result from current crc (trailer excluded from CRC), go to RESULT. Beat with SOP: set sticky ERR_SOP, restart crc and count from this beat as in IDLE (SOP+EOP here builds the result directly, carrying ERR_SOP).
  - RESULT: OUT_VALID=1 with all fields stable. IN_READY=0. When OUT_READY=1, go to IDLE next cycle and clear sticky errors.
- Timing:
  - An EOP beat accepted at edge N gives OUT_VALID=1 from cycle N+1.
  - The earliest next input acceptance is the edge after the result is accepted, giving one bubble per packet.
  - IN_READY=1 in IDLE and BODY.
- Length check: when count would exceed MAX_WORDS, set sticky ERR_LEN and saturate count at MAX_WORDS+1. The CRC keeps accumulating.
- OUT_CRC_OK = (crc_calc == IN_DATA[31:0] of the EOP beat) & ~ERR_LEN & ~ERR_SOP.
- When IN_VALID=0, no state changes.

Test Plan:
- Build with CRC_INIT=0. Send SOP beat 48'h000000000001, then EOP beat with [31:0]=32'h04C11DB7. Required: OUT_VALID one cycle after EOP, OUT_CRC_CALC=04C11DB7, OUT_CRC_OK=1, OUT_WORDS=1.
- Default CRC_INIT. Single SOP+EOP beat with [31:0]=32'hFFFFFFFF. Required: OUT_CRC_CALC=FFFFFFFF, OK=1, WORDS=0. Same beat with [31:0]=32'hFFFFFFFE: OK=0, OUT_CRC_RX=FFFFFFFE.
- Random 1..64-word packets against a serial bit-level model. Hold OUT_READY=0 for 5 cycles: IN_READY stays 0, outputs stay stable, and no beat is lost once the result is accepted.
- MAX_WORDS=4, send 6 payload beats plus a trailer matching the true CRC. Required: ERR_LEN=1, WORDS=5, OK=0.
- SOP, 2 beats, SOP, 1 beat, EOP. Required: one result with ERR_SOP=1, WORDS=1, CRC covering only the second packet. A stray non-SOP beat in IDLE produces no result.
- Assert RST in BODY and in RESULT. Required: OUT_VALID=0 next cycle, IN_READY=1 the cycle after, and a clean next packet checks OK.

Source files
------------

// File: rtl/crc32_rx_check.sv
// crc32_rx_check
//   Receive-side CRC-32 checker for a 48-bit word stream. Payload beats are
//   folded into a CRC-32 (poly 0x04C11DB7, MSB-first, no reflection, no final
//   XOR). The trailer beat (EOP) carries the received CRC in [31:0]. One
//   result record is produced per packet and held until accepted. Payload is
//   only observed, never stored or forwarded.
//
// Ports
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   IN_VALID/IN_READY input handshake; a beat transfers when both are high
//   IN_DATA[47:0]     payload word; on the EOP beat [31:0] is the received CRC
//   IN_SOP, IN_EOP    first beat / trailer beat (both high = zero payload)
//   OUT_VALID/OUT_READY result handshake; record held until accepted
//   OUT_CRC_OK        CRCs match and no protocol error was flagged
//   OUT_CRC_CALC      CRC computed over the payload
//   OUT_CRC_RX        CRC carried by the trailer
//   OUT_WORDS         payload beats, saturating at MAX_WORDS+1
//   OUT_ERR_LEN       payload exceeded MAX_WORDS
//   OUT_ERR_SOP       SOP seen inside an open packet; packet was restarted
module crc32_rx_check #(
    parameter logic [31:0] CRC_INIT  = 32'hFFFFFFFF,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [47:0] IN_DATA,
    input  logic        IN_SOP,
    input  logic        IN_EOP,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OUT_CRC_OK,
    output logic [31:0] OUT_CRC_CALC,
    output logic [31:0] OUT_CRC_RX,
    output logic [15:0] OUT_WORDS,
    output logic        OUT_ERR_LEN,
    output logic        OUT_ERR_SOP
);

    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);
    // MAX_WORDS = 65535 cannot saturate one above itself in 16 bits.
    localparam logic [15:0] SAT_W = (MAX_WORDS >= 65535) ? 16'hFFFF : 16'(MAX_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        BODY,
        RESULT
    } state_t;

    state_t      state, state_n;
    logic [31:0] crc, crc_n;
    logic [15:0] count, count_n;
    logic        err_len, err_len_n;
    logic        err_sop, err_sop_n;
    logic        ready_q;
    logic        accept;

    logic [31:0] step_cur, step_init;
    logic        load_res;
    logic [31:0] res_calc_n;
    logic [15:0] res_words_n;
    logic        res_len_n, res_sop_n, res_ok_n;

    logic        r_ok, r_len, r_sop;
    logic [31:0] r_calc, r_rx;
    logic [15:0] r_words;

    // 48 serial LFSR steps, IN_DATA[47] entering first.
    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [47:0] d_in);
        logic [31:0] c;
        logic [47:0] d;
        c = c_in;
        d = d_in;
        for (int unsigned i = 0; i < 48; i++) begin
            if (c[31] ^ d[47]) begin
                c = {c[30:0], 1'b0} ^ POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
            d = {d[46:0], 1'b0};
        end
        return c;
    endfunction

    assign accept    = IN_VALID & ready_q;
    assign step_cur  = crc_step(crc, IN_DATA);
    assign step_init = crc_step(CRC_INIT, IN_DATA);

    always_comb begin
        state_n     = state;
        crc_n       = crc;
        count_n     = count;
        err_len_n   = err_len;
        err_sop_n   = err_sop;
        load_res    = 1'b0;
        res_calc_n  = crc;
        res_words_n = count;
        res_len_n   = err_len;
        res_sop_n   = err_sop;

        case (state)
            IDLE: begin
                if (accept && IN_SOP) begin
                    if (IN_EOP) begin
                        load_res    = 1'b1;
                        res_calc_n  = CRC_INIT;
                        res_words_n = '0;
                        state_n     = RESULT;
                    end else begin
                        crc_n   = step_init;
                        count_n = 16'd1;
                        state_n = BODY;
                    end
                end
            end
            BODY: begin
                if (accept) begin
                    if (IN_SOP) begin
                        // Restart on a nested SOP; the error stays with the new packet.
                        err_sop_n = 1'b1;
                        if (IN_EOP) begin
                            load_res    = 1'b1;
                            res_calc_n  = CRC_INIT;
                            res_words_n = '0;
                            res_sop_n   = 1'b1;
                            state_n     = RESULT;
                        end else begin
                            crc_n   = step_init;
                            count_n = 16'd1;
                        end
                    end else if (IN_EOP) begin
                        load_res = 1'b1;
                        state_n  = RESULT;
                    end else begin
                        crc_n = step_cur;
                        if (count >= MAX_W) begin
                            count_n   = SAT_W;
                            err_len_n = 1'b1;
                        end else begin
                            count_n = count + 16'd1;
                        end
                    end
                end
            end
            RESULT: begin
                if (OUT_READY) begin
                    state_n   = IDLE;
                    crc_n     = CRC_INIT;
                    count_n   = '0;
                    err_len_n = 1'b0;
                    err_sop_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        res_ok_n = (res_calc_n == IN_DATA[31:0]) & ~res_len_n & ~res_sop_n;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            crc     <= CRC_INIT;
            count   <= '0;
            err_len <= 1'b0;
            err_sop <= 1'b0;
            ready_q <= 1'b0;
            r_ok    <= 1'b0;
            r_len   <= 1'b0;
            r_sop   <= 1'b0;
            r_calc  <= '0;
            r_rx    <= '0;
            r_words <= '0;
        end else begin
            state   <= state_n;
            crc     <= crc_n;
            count   <= count_n;
            err_len <= err_len_n;
            err_sop <= err_sop_n;
            ready_q <= (state_n != RESULT);
            if (load_res) begin
                r_ok    <= res_ok_n;
                r_len   <= res_len_n;
                r_sop   <= res_sop_n;
                r_calc  <= res_calc_n;
                r_rx    <= IN_DATA[31:0];
                r_words <= res_words_n;
            end
        end
    end

    assign IN_READY     = ready_q;
    assign OUT_VALID    = (state == RESULT);
    assign OUT_CRC_OK   = r_ok;
    assign OUT_CRC_CALC = r_calc;
    assign OUT_CRC_RX   = r_rx;
    assign OUT_WORDS    = r_words;
    assign OUT_ERR_LEN  = r_len;
    assign OUT_ERR_SOP  = r_sop;

endmodule

// File: tb/tb_crc32_rx_check.sv
// tb_crc32_rx_check
//   Drives one shared beat stream into three checker instances (default
//   parameters, CRC_INIT=0, MAX_WORDS=4). A packet-level reference model
//   pushes one expected record per instance into a queue; a monitor pops
//   and compares whenever a record is consumed.
module tb_crc32_rx_check;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    typedef struct packed {
        logic [31:0] calc;
        logic [31:0] rx;
        logic [15:0] words;
        logic        ok;
        logic        elen;
        logic        esop;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [47:0] in_data;
    logic        in_sop, in_eop;
    logic        out_ready;

    logic        rdy_a, vld_a, ok_a, elen_a, esop_a;
    logic [31:0] calc_a, rx_a;
    logic [15:0] words_a;
    logic        rdy_z, vld_z, ok_z, elen_z, esop_z;
    logic [31:0] calc_z, rx_z;
    logic [15:0] words_z;
    logic        rdy_m, vld_m, ok_m, elen_m, esop_m;
    logic [31:0] calc_m, rx_m;
    logic [15:0] words_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crc32_rx_check #(.CRC_INIT(32'hFFFFFFFF), .MAX_WORDS(1024)) u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy_a), .IN_DATA(in_data),
        .IN_SOP(in_sop), .IN_EOP(in_eop), .OUT_VALID(vld_a), .OUT_READY(out_ready),
        .OUT_CRC_OK(ok_a), .OUT_CRC_CALC(calc_a), .OUT_CRC_RX(rx_a), .OUT_WORDS(words_a),
        .OUT_ERR_LEN(elen_a), .OUT_ERR_SOP(esop_a));

    crc32_rx_check #(.CRC_INIT(32'h00000000), .MAX_WORDS(1024)) u_dut_init0 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy_z), .IN_DATA(in_data),
        .IN_SOP(in_sop), .IN_EOP(in_eop), .OUT_VALID(vld_z), .OUT_READY(out_ready),
        .OUT_CRC_OK(ok_z), .OUT_CRC_CALC(calc_z), .OUT_CRC_RX(rx_z), .OUT_WORDS(words_z),
        .OUT_ERR_LEN(elen_z), .OUT_ERR_SOP(esop_z));

    crc32_rx_check #(.CRC_INIT(32'hFFFFFFFF), .MAX_WORDS(4)) u_dut_max4 (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(rdy_m), .IN_DATA(in_data),
        .IN_SOP(in_sop), .IN_EOP(in_eop), .OUT_VALID(vld_m), .OUT_READY(out_ready),
        .OUT_CRC_OK(ok_m), .OUT_CRC_CALC(calc_m), .OUT_CRC_RX(rx_m), .OUT_WORDS(words_m),
        .OUT_ERR_LEN(elen_m), .OUT_ERR_SOP(esop_m));

    // ---------------- reference model ----------------
    logic [31:0] cfg_init [3] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    int          cfg_max  [3] = '{1024, 1024, 4};

    rec_t        exp_q [3][$];
    logic [47:0] cur [$];
    bit          pkt_open  = 0;
    bit          pkt_sop_e = 0;
    int          prior_max = 0;

    function automatic logic [31:0] ref_crc(input logic [31:0] init, input logic [47:0] w[$]);
        logic [31:0] c;
        logic [5:0]  bi;
        c = init;
        foreach (w[j]) begin
            for (int unsigned k = 0; k < 48; k++) begin
                bi = 6'(47 - k);
                if (c[31] ^ w[j][bi]) c = (c << 1) ^ POLY;
                else c = c << 1;
            end
        end
        return c;
    endfunction

    function automatic logic [47:0] rand48();
        return {16'($urandom()), $urandom()};
    endfunction

    task automatic model_flush();
        cur.delete();
        pkt_open  = 0;
        pkt_sop_e = 0;
        prior_max = 0;
        for (int k = 0; k < 3; k++) exp_q[k].delete();
    endtask

    task automatic model_beat(input logic [47:0] d, input bit sop, input bit eop, output bit produced);
        rec_t r;
        int   n;
        produced = 0;
        if (!pkt_open && !sop) return;
        if (sop) begin
            if (pkt_open) begin
                pkt_sop_e = 1;
                if (cur.size() > prior_max) prior_max = cur.size();
            end
            cur.delete();
            pkt_open = 1;
        end
        if (!eop) begin
            cur.push_back(d);
            return;
        end
        n = cur.size();
        for (int k = 0; k < 3; k++) begin
            r.calc  = ref_crc(cfg_init[k], cur);
            r.rx    = d[31:0];
            r.elen  = (n > cfg_max[k]) || (prior_max > cfg_max[k]);
            r.words = (n > cfg_max[k]) ? 16'(cfg_max[k] + 1) : 16'(n);
            r.esop  = pkt_sop_e;
            r.ok    = (r.calc == r.rx) && !r.elen && !r.esop;
            exp_q[k].push_back(r);
        end
        produced = 1;
        cur.delete();
        pkt_open  = 0;
        pkt_sop_e = 0;
        prior_max = 0;
    endtask

    // ---------------- result consumer ----------------
    int hold_cfg  = 0;
    bit rand_hold = 1;
    int hold_left = 0;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (vld_a && !out_ready) begin
                if (hold_left > 0) hold_left--;
                else out_ready = 1'b1;
            end else begin
                out_ready = 1'b0;
                hold_left = rand_hold ? int'($urandom_range(0, 5)) : hold_cfg;
            end
        end
    end

    // ---------------- monitor ----------------
    bit   held [3] = '{0, 0, 0};
    rec_t snap [3];

    always @(negedge clk) begin
        rec_t act [3];
        logic vld [3];
        logic rdy [3];
        rec_t e;
        act[0] = {calc_a, rx_a, words_a, ok_a, elen_a, esop_a};
        act[1] = {calc_z, rx_z, words_z, ok_z, elen_z, esop_z};
        act[2] = {calc_m, rx_m, words_m, ok_m, elen_m, esop_m};
        vld = '{vld_a, vld_z, vld_m};
        rdy = '{rdy_a, rdy_z, rdy_m};
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (vld[k]) begin
                    checks++;
                    if (rdy[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL in_ready_during_result[%0d]: got %b, expected 0", k, rdy[k]);
                    end
                    if (held[k]) begin
                        checks++;
                        if (act[k] !== snap[k]) begin
                            errors++;
                            $display("FAIL result_stable[%0d]: got %h, expected %h", k, act[k], snap[k]);
                        end
                    end
                    snap[k] = act[k];
                    held[k] = 1;
                    if (out_ready) begin
                        held[k] = 0;
                        checks++;
                        if (exp_q[k].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_result[%0d]: got record %h, expected none", k, act[k]);
                        end else begin
                            e = exp_q[k].pop_front();
                            if (act[k] !== e) begin
                                errors++;
                                $display("FAIL result[%0d]: got calc=%h rx=%h words=%0d ok=%b len=%b sop=%b, expected calc=%h rx=%h words=%0d ok=%b len=%b sop=%b",
                                         k, act[k].calc, act[k].rx, act[k].words, act[k].ok, act[k].elen, act[k].esop,
                                         e.calc, e.rx, e.words, e.ok, e.elen, e.esop);
                            end
                        end
                    end
                end else begin
                    held[k] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_cycle();
        in_valid = 1'b0;
        in_data  = rand48();
        in_sop   = 1'($urandom_range(0, 1));
        in_eop   = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        in_sop = 1'b0;
        in_eop = 1'b0;
    endtask

    task automatic send_beat(input logic [47:0] d, input bit sop, input bit eop);
        bit done;
        bit produced;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        done = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (rdy_a) done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        model_beat(d, sop, eop, produced);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        if (produced) begin
            checks++;
            if ({vld_a, vld_z, vld_m} !== 3'b111) begin
                errors++;
                $display("FAIL eop_latency: got out_valid=%b, expected 111", {vld_a, vld_z, vld_m});
            end
        end
    endtask

    task automatic send_packet(input int n, input bit good, input bit gaps);
        logic [47:0] w [$];
        logic [31:0] c;
        for (int i = 0; i < n; i++) w.push_back(rand48());
        c = ref_crc(32'hFFFFFFFF, w);
        if (!good) c = c ^ 32'($urandom_range(1, 65535));
        for (int i = 0; i < n; i++) begin
            send_beat(w[i], (i == 0), 1'b0);
            if (gaps && $urandom_range(0, 3) == 0) idle_cycle();
        end
        send_beat({16'($urandom()), c}, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        @(posedge clk);
        #1;
        model_flush();
        checks++;
        if ({vld_a, vld_z, vld_m} !== 3'b000 || {rdy_a, rdy_z, rdy_m} !== 3'b000) begin
            errors++;
            $display("FAIL reset_handshake: got valid=%b ready=%b, expected 000/000",
                     {vld_a, vld_z, vld_m}, {rdy_a, rdy_z, rdy_m});
        end
        checks++;
        if ({calc_a, rx_a, words_a, ok_a, elen_a, esop_a} !== '0 ||
            {calc_z, rx_z, words_z, ok_z, elen_z, esop_z} !== '0 ||
            {calc_m, rx_m, words_m, ok_m, elen_m, esop_m} !== '0) begin
            errors++;
            $display("FAIL reset_data: got calc=%h/%h/%h words=%0d/%0d/%0d, expected all zero",
                     calc_a, calc_z, calc_m, words_a, words_z, words_m);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({rdy_a, rdy_z, rdy_m} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, expected 111", {rdy_a, rdy_z, rdy_m});
        end
    endtask

    initial begin
        logic [47:0] w [$];
        logic [31:0] c;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        do_reset();

        // one-word packet, trailer equal to the CRC_INIT=0 result
        send_beat(48'h000000000001, 1'b1, 1'b0);
        send_beat({16'h0000, 32'h04C11DB7}, 1'b0, 1'b1);

        // zero-payload packets, matching and off-by-one trailer
        send_beat({16'hABCD, 32'hFFFFFFFF}, 1'b1, 1'b1);
        send_beat({16'h1234, 32'hFFFFFFFE}, 1'b1, 1'b1);

        // stray beats while idle produce nothing
        send_beat(rand48(), 1'b0, 1'b0);
        send_beat(rand48(), 1'b0, 1'b1);

        // six payload beats with a correct trailer (length error on MAX_WORDS=4)
        send_packet(6, 1'b1, 1'b0);

        // nested SOP: SOP + 2 beats, SOP + EOP trailer covering only the last word
        w.delete();
        w.push_back(rand48());
        c = ref_crc(32'hFFFFFFFF, w);
        send_beat(rand48(), 1'b1, 1'b0);
        send_beat(rand48(), 1'b0, 1'b0);
        send_beat(rand48(), 1'b0, 1'b0);
        send_beat(w[0], 1'b1, 1'b0);
        send_beat({16'h0000, c}, 1'b0, 1'b1);

        // nested SOP+EOP inside an open packet
        send_beat(rand48(), 1'b1, 1'b0);
        send_beat({16'h0000, 32'hFFFFFFFF}, 1'b1, 1'b1);

        // long backpressure, next packet queued behind the held result
        rand_hold = 0;
        hold_cfg  = 5;
        send_packet(3, 1'b1, 1'b0);
        send_packet(2, 1'b1, 1'b0);
        send_packet(1, 1'b0, 1'b0);
        rand_hold = 1;

        // randomized traffic
        for (int p = 0; p < 40; p++) begin
            send_packet(int'($urandom_range(1, 64)), ($urandom_range(0, 1) == 1), 1'b1);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        // reset mid-packet, then a clean packet
        send_beat(rand48(), 1'b1, 1'b0);
        send_beat(rand48(), 1'b0, 1'b0);
        do_reset();
        send_packet(5, 1'b1, 1'b0);

        // reset while a result is pending, then a clean packet
        rand_hold = 0;
        hold_cfg  = 1000;
        send_packet(3, 1'b1, 1'b0);
        do_reset();
        hold_cfg  = 0;
        rand_hold = 1;
        send_packet(4, 1'b1, 1'b0);

        for (int t = 0; t < 100 && (exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0; t++)
            @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (exp_q[k].size() != 0) begin
                errors++;
                $display("FAIL results_drained[%0d]: got %0d pending, expected 0", k, exp_q[k].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion within 2 ms, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
